regfile_wb_arbiter: RTL and testbench

//  Shares the single write ports of the A-bank (48b, A0 hard-zero) and D-bank (48b) register files between

---
 rtl/regfile_wb_arbiter_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the regfile writeback arbiter: bank encodings,
// capability field widths and a register-index decoder.
package regfile_wb_arbiter_pkg;

   // Register-file bank select carried on req_bank / rsv_bank.
   typedef enum logic {
      WbBankA = 1'b0,
      WbBankD = 1'b1
   } wb_bank_e;

   // Capability field widths used when WB_ARB_CAP_EN is defined.
   localparam int unsigned CapAddrWidth = 32;
   localparam int unsigned CapPermWidth = 8;

   // Decode a 3-bit register index to its scoreboard bit.
   function automatic logic [7:0] addr_onehot(input logic [2:0] addr);
      return 8'b1 << addr;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer, wrapping modulo NREQ. The pointer moves past the winner on a grant
// and holds when nobody requests.
module regfile_wb_arbiter_rr_arbiter #(
   parameter int unsigned NREQ = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   output logic [NREQ-1:0] gnt_o
);

   localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [PtrW-1:0] win;
   logic            found;

   // Search from the pointer, take the first requester, derive the next pointer.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      win   = ptr_q;
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned idx;
         idx = (32'(ptr_q) + k) % NREQ;
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            win        = PtrW'(idx);
            gnt_o[idx] = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the A (A0 hard-zero) and D register banks. One
// round-robin arbiter per bank, a registered write-port stage and a pending
// write scoreboard for issue. Optional capability write path: WB_ARB_CAP_EN.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 3,
   parameter int unsigned DW   = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_bank,
   input  logic [NREQ*3-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic              rsv_valid,
   input  logic              rsv_bank,
   input  logic [2:0]        rsv_addr,
   output logic              a_we,
   output logic [2:0]        a_waddr,
   output logic [DW-1:0]     a_wdata,
   output logic              d_we,
   output logic [2:0]        d_waddr,
   output logic [DW-1:0]     d_wdata,
   output logic [7:0]        pending_a,
   output logic [7:0]        pending_d
`ifdef WB_ARB_CAP_EN
   ,
   input  logic [NREQ-1:0]              req_cap_we,
   input  logic [NREQ-1:0]              req_cap_valid,
   input  logic [NREQ*CapAddrWidth-1:0] req_cap_base,
   input  logic [NREQ*CapAddrWidth-1:0] req_cap_limit,
   input  logic [NREQ*CapPermWidth-1:0] req_cap_perms,
   output logic                         cap_we,
   output logic [2:0]                   cap_waddr,
   output logic                         cap_valid_o,
   output logic [CapAddrWidth-1:0]      cap_base_o,
   output logic [CapAddrWidth-1:0]      cap_limit_o,
   output logic [CapPermWidth-1:0]      cap_perms_o
`endif
);

   logic [NREQ-1:0] cand_a, cand_d, gnt_a, gnt_d;
   logic [2:0]      a_sel_addr, d_sel_addr;
   logic [DW-1:0]   a_sel_data, d_sel_data;
   logic            a_we_q, a_we_d, d_we_q, d_we_d;
   logic [2:0]      a_waddr_q, d_waddr_q;
   logic [DW-1:0]   a_wdata_q, d_wdata_q;
   logic [7:0]      pending_a_q, pending_a_d, pending_d_q, pending_d_d;
   logic [7:0]      set_a, set_d, clr_a, clr_d;

   // Split valid requests into per-bank candidate sets.
   always_comb begin
      cand_a = '0;
      cand_d = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand_a[i] = req_valid[i] && (req_bank[i] == WbBankA);
         cand_d[i] = req_valid[i] && (req_bank[i] == WbBankD);
      end
   end

   regfile_wb_arbiter_rr_arbiter #(.NREQ(NREQ)) u_arb_a (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (cand_a),
      .gnt_o (gnt_a)
   );

   regfile_wb_arbiter_rr_arbiter #(.NREQ(NREQ)) u_arb_d (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (cand_d),
      .gnt_o (gnt_d)
   );

   // Ready is forced low while reset is asserted, independent of the clock.
   assign req_ready = (gnt_a | gnt_d) & {NREQ{rst_n}};

   // AND-OR mux of the winning request per bank; grants are one-hot.
   always_comb begin
      a_sel_addr = '0;
      a_sel_data = '0;
      d_sel_addr = '0;
      d_sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_a[i]) begin
            a_sel_addr |= req_addr[3*i +: 3];
            a_sel_data |= req_data[DW*i +: DW];
         end
         if (gnt_d[i]) begin
            d_sel_addr |= req_addr[3*i +: 3];
            d_sel_data |= req_data[DW*i +: DW];
         end
      end
      // A0 is hard-zero: the write is accepted but never reaches the port.
      a_we_d = (|gnt_a) && (a_sel_addr != 3'd0);
      d_we_d = |gnt_d;
   end

   // Scoreboard: a same-edge reservation beats the commit clear.
   always_comb begin
      set_a = (rsv_valid && (rsv_bank == WbBankA) && (rsv_addr != 3'd0)) ?
              addr_onehot(rsv_addr) : 8'h00;
      set_d = (rsv_valid && (rsv_bank == WbBankD)) ? addr_onehot(rsv_addr) : 8'h00;
      clr_a = a_we_q ? addr_onehot(a_waddr_q) : 8'h00;
      clr_d = d_we_q ? addr_onehot(d_waddr_q) : 8'h00;
      pending_a_d = ((pending_a_q & ~clr_a) | set_a) & 8'hFE;
      pending_d_d = (pending_d_q & ~clr_d) | set_d;
   end

   // Registered write-port stage and scoreboard state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_we_q      <= 1'b0;
         a_waddr_q   <= '0;
         a_wdata_q   <= '0;
         d_we_q      <= 1'b0;
         d_waddr_q   <= '0;
         d_wdata_q   <= '0;
         pending_a_q <= '0;
         pending_d_q <= '0;
      end else begin
         a_we_q      <= a_we_d;
         a_waddr_q   <= a_sel_addr;
         a_wdata_q   <= a_sel_data;
         d_we_q      <= d_we_d;
         d_waddr_q   <= d_sel_addr;
         d_wdata_q   <= d_sel_data;
         pending_a_q <= pending_a_d;
         pending_d_q <= pending_d_d;
      end
   end

   assign a_we      = a_we_q;
   assign a_waddr   = a_waddr_q;
   assign a_wdata   = a_wdata_q;
   assign d_we      = d_we_q;
   assign d_waddr   = d_waddr_q;
   assign d_wdata   = d_wdata_q;
   assign pending_a = pending_a_q;
   assign pending_d = pending_d_q;

`ifdef WB_ARB_CAP_EN
   logic                    cap_we_q, cap_we_d, cap_valid_q, cap_valid_d;
   logic [2:0]              cap_waddr_q;
   logic [CapAddrWidth-1:0] cap_base_q, cap_base_d, cap_limit_q, cap_limit_d;
   logic [CapPermWidth-1:0] cap_perms_q, cap_perms_d;

   // Cap fields follow the A-bank winner; D requests never write caps.
   always_comb begin
      cap_we_d    = 1'b0;
      cap_valid_d = 1'b0;
      cap_base_d  = '0;
      cap_limit_d = '0;
      cap_perms_d = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_a[i]) begin
            cap_we_d    |= req_cap_we[i];
            cap_valid_d |= req_cap_valid[i];
            cap_base_d  |= req_cap_base[CapAddrWidth*i +: CapAddrWidth];
            cap_limit_d |= req_cap_limit[CapAddrWidth*i +: CapAddrWidth];
            cap_perms_d |= req_cap_perms[CapPermWidth*i +: CapPermWidth];
         end
      end
      cap_we_d = cap_we_d && a_we_d;
   end

   // Capability write-port register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_we_q    <= 1'b0;
         cap_waddr_q <= '0;
         cap_valid_q <= 1'b0;
         cap_base_q  <= '0;
         cap_limit_q <= '0;
         cap_perms_q <= '0;
      end else begin
         cap_we_q    <= cap_we_d;
         cap_waddr_q <= a_sel_addr;
         cap_valid_q <= cap_valid_d;
         cap_base_q  <= cap_base_d;
         cap_limit_q <= cap_limit_d;
         cap_perms_q <= cap_perms_d;
      end
   end

   assign cap_we      = cap_we_q;
   assign cap_waddr   = cap_waddr_q;
   assign cap_valid_o = cap_valid_q;
   assign cap_base_o  = cap_base_q;
   assign cap_limit_o = cap_limit_q;
   assign cap_perms_o = cap_perms_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3, DW=48). Cap path checks are
// compiled in with WB_ARB_CAP_EN.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   localparam int unsigned NREQ = 3;
   localparam int unsigned DW   = 48;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid, req_ready, req_bank;
   logic [NREQ*3-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic              rsv_valid, rsv_bank;
   logic [2:0]        rsv_addr;
   logic              a_we, d_we;
   logic [2:0]        a_waddr, d_waddr;
   logic [DW-1:0]     a_wdata, d_wdata;
   logic [7:0]        pending_a, pending_d;
`ifdef WB_ARB_CAP_EN
   logic [NREQ-1:0]              req_cap_we, req_cap_valid;
   logic [NREQ*CapAddrWidth-1:0] req_cap_base, req_cap_limit;
   logic [NREQ*CapPermWidth-1:0] req_cap_perms;
   logic                         cap_we, cap_valid_o;
   logic [2:0]                   cap_waddr;
   logic [CapAddrWidth-1:0]      cap_base_o, cap_limit_o;
   logic [CapPermWidth-1:0]      cap_perms_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_bank  (req_bank),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rsv_valid (rsv_valid),
      .rsv_bank  (rsv_bank),
      .rsv_addr  (rsv_addr),
      .a_we      (a_we),
      .a_waddr   (a_waddr),
      .a_wdata   (a_wdata),
      .d_we      (d_we),
      .d_waddr   (d_waddr),
      .d_wdata   (d_wdata),
      .pending_a (pending_a),
      .pending_d (pending_d)
`ifdef WB_ARB_CAP_EN
      ,
      .req_cap_we    (req_cap_we),
      .req_cap_valid (req_cap_valid),
      .req_cap_base  (req_cap_base),
      .req_cap_limit (req_cap_limit),
      .req_cap_perms (req_cap_perms),
      .cap_we        (cap_we),
      .cap_waddr     (cap_waddr),
      .cap_valid_o   (cap_valid_o),
      .cap_base_o    (cap_base_o),
      .cap_limit_o   (cap_limit_o),
      .cap_perms_o   (cap_perms_o)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_bank  = '0;
      req_addr  = '0;
      req_data  = '0;
`ifdef WB_ARB_CAP_EN
      req_cap_we    = '0;
      req_cap_valid = '0;
      req_cap_base  = '0;
      req_cap_limit = '0;
      req_cap_perms = '0;
`endif
   endtask

   task automatic set_req(input int i, input logic bank, input logic [2:0] addr,
                          input logic [DW-1:0] data);
      req_valid[i]         = 1'b1;
      req_bank[i]          = bank;
      req_addr[3*i +: 3]   = addr;
      req_data[DW*i +: DW] = data;
   endtask

   task automatic rsv(input logic v, input logic bank, input logic [2:0] addr);
      rsv_valid = v;
      rsv_bank  = bank;
      rsv_addr  = addr;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_reqs();
      rsv(1'b0, 1'b0, 3'd0);
      req_valid = 3'b111;
      cyc();
      cyc();
      // Reset state, with requests present
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_a_we", 64'(a_we), 64'h0);
      check("rst_d_we", 64'(d_we), 64'h0);
      check("rst_pend", 64'({pending_a, pending_d}), 64'h0);
      clear_reqs();
      rst_n = 1'b1;
      cyc();

      // Three A requesters held valid: grants 0, 1, 2, then pointer wraps
      set_req(0, 1'b0, 3'd1, 48'h111);
      set_req(1, 1'b0, 3'd2, 48'h222);
      set_req(2, 1'b0, 3'd4, 48'h444);
      #1 check("rr_rdy0", 64'(req_ready), 64'h1);
      cyc();
      check("rr_wa0", 64'({a_we, a_waddr}), 64'h9);
      check("rr_wd0", 64'(a_wdata), 64'h111);
      req_valid[0] = 1'b0;
      #1 check("rr_rdy1", 64'(req_ready), 64'h2);
      cyc();
      check("rr_wa1", 64'({a_we, a_waddr}), 64'hA);
      req_valid[1] = 1'b0;
      #1 check("rr_rdy2", 64'(req_ready), 64'h4);
      cyc();
      check("rr_wa2", 64'({a_we, a_waddr}), 64'hC);
      check("rr_wd2", 64'(a_wdata), 64'h444);
      clear_reqs();
      set_req(0, 1'b0, 3'd1, 48'h5);
      set_req(1, 1'b0, 3'd2, 48'h6);
      #1 check("rr_wrap", 64'(req_ready), 64'h1);
      cyc();
      clear_reqs();
      check("rr_wrap_wa", 64'({a_we, a_waddr}), 64'h9);
      cyc();
      check("idle_a_we", 64'(a_we), 64'h0);

      // Same-cycle A and D writes from different requesters
      set_req(0, 1'b0, 3'd3, 48'h1234);
      set_req(1, 1'b1, 3'd5, 48'hBEEF);
      #1 check("ad_rdy", 64'(req_ready), 64'h3);
      cyc();
      clear_reqs();
      check("ad_a", 64'({a_we, a_waddr}), 64'hB);
      check("ad_awd", 64'(a_wdata), 64'h1234);
      check("ad_d", 64'({d_we, d_waddr}), 64'hD);
      check("ad_dwd", 64'(d_wdata), 64'hBEEF);
      cyc();
      check("ad_idle", 64'({a_we, d_we}), 64'h0);

      // A0 write: accepted but no port write
      set_req(1, 1'b0, 3'd0, 48'h55);
      #1 check("a0_rdy", 64'(req_ready), 64'h2);
      cyc();
      clear_reqs();
      check("a0_we", 64'(a_we), 64'h0);
      check("a0_pend", 64'(pending_a), 64'h0);

      // Scoreboard set/clear, reserve of A0 ignored
      rsv(1'b1, 1'b0, 3'd6);
      cyc();
      check("sb_a6", 64'(pending_a), 64'h40);
      rsv(1'b1, 1'b1, 3'd2);
      cyc();
      rsv(1'b1, 1'b0, 3'd0);
      check("sb_d2", 64'(pending_d), 64'h04);
      cyc();
      rsv(1'b0, 1'b0, 3'd0);
      check("sb_a0_ign", 64'(pending_a), 64'h40);
      set_req(2, 1'b0, 3'd6, 48'h66);
      cyc();
      clear_reqs();
      rsv(1'b1, 1'b0, 3'd6);         // re-reserve on the commit edge
      check("sb_cm_we", 64'({a_we, a_waddr}), 64'hE);
      cyc();
      rsv(1'b0, 1'b0, 3'd0);
      check("sb_keep", 64'(pending_a), 64'h40);
      set_req(2, 1'b0, 3'd6, 48'h77);
      set_req(0, 1'b1, 3'd2, 48'h22);
      cyc();
      clear_reqs();
      cyc();
      check("sb_clr_a", 64'(pending_a), 64'h00);
      check("sb_clr_d", 64'(pending_d), 64'h00);
      // Double reservation: one commit still clears
      rsv(1'b1, 1'b1, 3'd7);
      cyc();
      cyc();
      rsv(1'b0, 1'b0, 3'd0);
      set_req(1, 1'b1, 3'd7, 48'h7);
      cyc();
      clear_reqs();
      check("sb_dbl_set", 64'(pending_d), 64'h80);
      cyc();
      check("sb_dbl_clr", 64'(pending_d), 64'h00);

      // Asynchronous reset mid-traffic
      rsv(1'b1, 1'b0, 3'd3);
      cyc();
      rsv(1'b0, 1'b0, 3'd0);
      set_req(0, 1'b0, 3'd3, 48'hAA);
      set_req(1, 1'b1, 3'd1, 48'hBB);
      cyc();
      check("mid_busy", 64'({a_we, d_we, pending_a}), 64'h308);
      #2 rst_n = 1'b0;
      #1;
      check("mid_we", 64'({a_we, d_we}), 64'h0);
      check("mid_pend", 64'({pending_a, pending_d}), 64'h0);
      check("mid_rdy", 64'(req_ready), 64'h0);
      clear_reqs();
      cyc();
      rst_n = 1'b1;
      cyc();
      check("mid_lost", 64'({a_we, d_we}), 64'h0);

`ifdef WB_ARB_CAP_EN
      // Capability write alongside an A write
      set_req(2, 1'b0, 3'd7, 48'h99);
      req_cap_we[2]                            = 1'b1;
      req_cap_base[CapAddrWidth*2 +: CapAddrWidth] = 32'h100;
      cyc();
      clear_reqs();
      check("cap_we", 64'({cap_we, a_we}), 64'h3);
      check("cap_base", 64'(cap_base_o), 64'h100);
      check("cap_waddr", 64'(cap_waddr), 64'h7);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
